key_debounce: RTL and testbench



---
 rtl/key_debounce.sv | 118 +++++++++++
 tb/tb_key_debounce.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce.sv
// Key debouncer: two-flop synchroniser, hold-time filter FSM, and registered
// debounced level plus single-cycle press/release pulses.
module key_debounce #(
   parameter int unsigned CNT_MAX        = 999_999,
   parameter bit          KEY_ACTIVE_LOW = 1'b1
) (
   input  logic sys_clk,
   input  logic sys_rst,
   input  logic key_in,
   output logic key_flag,
   output logic key_release,
   output logic key_level
);

   localparam int unsigned       CNT_W    = $clog2(CNT_MAX);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CNT_MAX - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
   localparam logic              IDLE_LVL = KEY_ACTIVE_LOW ? 1'b1 : 1'b0;

   typedef enum logic [1:0] {
      IDLE,
      PRESS_FILT,
      PRESSED,
      REL_FILT
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              key_s1_q, key_s1_d;
   logic              key_s2_q, key_s2_d;
   logic              flag_q, flag_d;
   logic              release_q, release_d;
   logic              level_q, level_d;
   logic              pressed;

   // Synchroniser flops reset to the idle key level so reset never looks like a press.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         key_s1_q  <= IDLE_LVL;
         key_s2_q  <= IDLE_LVL;
         state_q   <= IDLE;
         cnt_q     <= '0;
         flag_q    <= 1'b0;
         release_q <= 1'b0;
         level_q   <= 1'b0;
      end else begin
         key_s1_q  <= key_s1_d;
         key_s2_q  <= key_s2_d;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         flag_q    <= flag_d;
         release_q <= release_d;
         level_q   <= level_d;
      end
   end

   assign pressed = KEY_ACTIVE_LOW ? ~key_s2_q : key_s2_q;

   always_comb begin
      key_s1_d  = key_in;
      key_s2_d  = key_s1_q;
      state_d   = state_q;
      cnt_d     = cnt_q;
      flag_d    = 1'b0;
      release_d = 1'b0;
      level_d   = level_q;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (pressed) begin
               state_d = PRESS_FILT;
            end
         end
         PRESS_FILT: begin
            if (!pressed) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = PRESSED;
               cnt_d   = '0;
               flag_d  = 1'b1;
               level_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         PRESSED: begin
            cnt_d = '0;
            if (!pressed) begin
               state_d = REL_FILT;
            end
         end
         REL_FILT: begin
            // A return to pressed here is release bounce: resume holding with no pulse.
            if (pressed) begin
               state_d = PRESSED;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d   = IDLE;
               cnt_d     = '0;
               release_d = 1'b1;
               level_d   = 1'b0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign key_flag    = flag_q;
   assign key_release = release_q;
   assign key_level   = level_q;

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce: run-length reference model compared
// every cycle, plus directed latency, bounce and mid-operation reset scenarios.
module tb_key_debounce;

   localparam int   CNT_MAX   = 4;
   localparam logic PRESS_LVL = 1'b0;
   localparam logic IDLE_LVL  = 1'b1;

   logic sys_clk = 1'b0;
   logic sys_rst = 1'b0;
   logic key_in  = IDLE_LVL;
   logic key_flag, key_release, key_level;

   int pass_cnt  = 0;
   int check_cnt = 0;
   int edge_cnt  = 0;
   int flag_cnt  = 0;
   int rel_cnt   = 0;
   int flag_edge = -1;
   int rel_edge  = -1;
   int fall_edge = -1;
   logic prev_level = 1'b0;
   bit check_en = 1'b0;

   key_debounce #(
      .CNT_MAX        (CNT_MAX),
      .KEY_ACTIVE_LOW (1'b1)
   ) dut (
      .sys_clk     (sys_clk),
      .sys_rst     (sys_rst),
      .key_in      (key_in),
      .key_flag    (key_flag),
      .key_release (key_release),
      .key_level   (key_level)
   );

   always #10 sys_clk = ~sys_clk;

   always @(posedge sys_clk) edge_cnt <= edge_cnt + 1;

   // Reference: the level flips once the synchronised key has disagreed with it
   // for CNT_MAX+1 consecutive edges; any agreement restarts the run.
   logic m_pipe0, m_pipe1, m_level, m_flag, m_rel;
   int   m_run;
   logic m_seen, m_mismatch, m_accept;

   assign m_seen     = (m_pipe1 == PRESS_LVL);
   assign m_mismatch = (m_seen != m_level);
   assign m_accept   = m_mismatch && (m_run == CNT_MAX);

   always @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         m_pipe0 <= IDLE_LVL;
         m_pipe1 <= IDLE_LVL;
         m_level <= 1'b0;
         m_flag  <= 1'b0;
         m_rel   <= 1'b0;
         m_run   <= 0;
      end else begin
         m_pipe0 <= key_in;
         m_pipe1 <= m_pipe0;
         m_run   <= (m_mismatch && !m_accept) ? m_run + 1 : 0;
         m_level <= m_accept ? ~m_level : m_level;
         m_flag  <= m_accept && !m_level;
         m_rel   <= m_accept && m_level;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      check_cnt++;
      if (actual === expected) begin
         pass_cnt++;
      end else begin
         $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Per-cycle comparison against the model, plus pulse/edge bookkeeping.
   always @(negedge sys_clk) begin
      if (check_en) begin
         checkOutput("model_flag", {31'd0, key_flag}, {31'd0, m_flag});
         checkOutput("model_release", {31'd0, key_release}, {31'd0, m_rel});
         checkOutput("model_level", {31'd0, key_level}, {31'd0, m_level});
      end
      if (key_flag === 1'b1) begin
         flag_cnt  <= flag_cnt + 1;
         flag_edge <= edge_cnt;
      end
      if (key_release === 1'b1) begin
         rel_cnt  <= rel_cnt + 1;
         rel_edge <= edge_cnt;
      end
      if (prev_level === 1'b1 && key_level === 1'b0) begin
         fall_edge <= edge_cnt;
      end
      prev_level <= key_level;
   end

   task automatic applyStimulus(input logic lvl, input int cycles, output int k);
      @(negedge sys_clk);
      key_in = lvl;
      k = edge_cnt + 1;
      repeat (cycles - 1) @(negedge sys_clk);
   endtask

   initial begin
      int k, f0, r0, total, len, diff;
      bit seen;
      logic lvl;

      #1 sys_rst = 1'b1;
      #1 check_en = 1'b1;
      checkOutput("reset_flag", {31'd0, key_flag}, 32'd0);
      checkOutput("reset_release", {31'd0, key_release}, 32'd0);
      checkOutput("reset_level", {31'd0, key_level}, 32'd0);
      repeat (2) @(negedge sys_clk);
      #3 sys_rst = 1'b0;

      f0 = flag_cnt;
      applyStimulus(IDLE_LVL, 50, k);
      checkOutput("idle_no_flag", flag_cnt - f0, 32'd0);
      checkOutput("idle_level", {31'd0, key_level}, 32'd0);

      f0 = flag_cnt;
      r0 = rel_cnt;
      applyStimulus(PRESS_LVL, 30, k);
      checkOutput("press_latency", flag_edge - k, 32'd6);
      checkOutput("press_one_flag", flag_cnt - f0, 32'd1);
      checkOutput("press_no_release", rel_cnt - r0, 32'd0);
      checkOutput("press_level", {31'd0, key_level}, 32'd1);

      f0 = flag_cnt;
      r0 = rel_cnt;
      applyStimulus(IDLE_LVL, 2, k);
      applyStimulus(PRESS_LVL, 2, k);
      applyStimulus(IDLE_LVL, 30, k);
      checkOutput("release_latency", rel_edge - k, 32'd6);
      checkOutput("release_level_fall", fall_edge - k, 32'd6);
      checkOutput("release_one_pulse", rel_cnt - r0, 32'd1);
      checkOutput("release_no_flag", flag_cnt - f0, 32'd0);

      f0 = flag_cnt;
      applyStimulus(PRESS_LVL, 3, k);
      applyStimulus(IDLE_LVL, 2, k);
      applyStimulus(PRESS_LVL, 2, k);
      applyStimulus(IDLE_LVL, 20, k);
      checkOutput("bounce_no_flag", flag_cnt - f0, 32'd0);
      checkOutput("bounce_level", {31'd0, key_level}, 32'd0);

      // Reset while the press filter is running.
      applyStimulus(PRESS_LVL, 3, k);
      @(posedge sys_clk);
      #7 sys_rst = 1'b1;
      #1;
      checkOutput("rst_filt_flag", {31'd0, key_flag}, 32'd0);
      checkOutput("rst_filt_release", {31'd0, key_release}, 32'd0);
      checkOutput("rst_filt_level", {31'd0, key_level}, 32'd0);
      @(negedge sys_clk);
      #3 sys_rst = 1'b0;
      k = edge_cnt + 1;
      f0 = flag_cnt;
      repeat (20) @(negedge sys_clk);
      checkOutput("rst_filt_refilter", flag_edge - k, 32'd6);
      checkOutput("rst_filt_one_flag", flag_cnt - f0, 32'd1);

      // Reset while held in PRESSED, then again with a press pulse in flight.
      @(posedge sys_clk);
      #5 sys_rst = 1'b1;
      #1;
      checkOutput("rst_pressed_level", {31'd0, key_level}, 32'd0);
      @(negedge sys_clk);
      #3 sys_rst = 1'b0;
      k = edge_cnt + 1;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge sys_clk);
         if (key_flag === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      checkOutput("rst_pressed_flag_seen", {31'd0, seen}, 32'd1);
      checkOutput("rst_pressed_refilter", edge_cnt - k, 32'd6);
      #2 sys_rst = 1'b1;
      #1;
      checkOutput("rst_inflight_flag", {31'd0, key_flag}, 32'd0);
      checkOutput("rst_inflight_level", {31'd0, key_level}, 32'd0);
      @(negedge sys_clk);
      #3 sys_rst = 1'b0;
      k = edge_cnt + 1;
      f0 = flag_cnt;
      repeat (20) @(negedge sys_clk);
      checkOutput("rst_inflight_refilter", flag_edge - k, 32'd6);
      checkOutput("rst_inflight_one_flag", flag_cnt - f0, 32'd1);

      applyStimulus(IDLE_LVL, 20, k);

      f0 = flag_cnt;
      r0 = rel_cnt;
      total = 0;
      while (total < 2000) begin
         lvl = 1'($urandom_range(0, 1));
         len = int'($urandom_range(1, 12));
         applyStimulus(lvl, len, k);
         total += len;
      end
      repeat (2) @(negedge sys_clk);
      diff = (flag_cnt - f0) - (rel_cnt - r0);
      checkOutput("random_balance", {31'd0, (diff == 0 || diff == 1)}, 32'd1);
      checkOutput("random_has_flags", {31'd0, (flag_cnt - f0) > 0}, 32'd1);

      check_en = 1'b0;
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
